alu_issue_stage: RTL

Decode/issue stage directly upstream of the ALU, plus writeback of its result. It accepts 32-bit instructions over a valid/ready handshake and reads source operands from the register file. It drives registered operands and opcode into the ALU, tracks the in-flight result through the ALU's one-cycle registered latency, and writes it back. RAW hazards are resolved by forwarding from the ALU result or a one-cycle stall.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/alu_hazard_unit.sv | 22 ++
 rtl/alu_issue_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants and instruction field layout for the ALU issue path.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_XNOR = 5'b01010;

  localparam int F_OP_LSB  = 27;
  localparam int F_RD_LSB  = 22;
  localparam int F_RS1_LSB = 17;
  localparam int F_RS2_LSB = 12;
  localparam int F_SH_LSB  = 7;
  localparam int F_IMM_BIT = 6;

  typedef struct packed {
    logic [REGW-1:0] opcode;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] shamt;
    logic            use_imm;
    logic [5:0]      imm6;
  } instr_t;

  function automatic instr_t decode(input logic [XLEN-1:0] w);
    instr_t d;
    d.opcode  = w[F_OP_LSB  +: REGW];
    d.rd      = w[F_RD_LSB  +: REGW];
    d.rs1     = w[F_RS1_LSB +: REGW];
    d.rs2     = w[F_RS2_LSB +: REGW];
    d.shamt   = w[F_SH_LSB  +: REGW];
    d.use_imm = w[F_IMM_BIT];
    d.imm6    = w[5:0];
    return d;
  endfunction
endpackage

// File: rtl/alu_hazard_unit.sv
// RAW check of the offered instruction against the X slot (stall) and A slot (forward).
module alu_hazard_unit
  import cpu_pkg::*;
(
  input  logic            instr_valid,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic            use_imm,
  input  logic            x_valid,
  input  logic [REGW-1:0] x_rd,
  input  logic            a_valid,
  input  logic [REGW-1:0] a_rd,
  output logic            stall,
  output logic            fwd1,
  output logic            fwd2
);
  // X result is not out of the ALU yet, so a match there can only be solved by waiting
  assign stall = instr_valid && x_valid && (x_rd != '0) &&
                 ((rs1 == x_rd) || (!use_imm && (rs2 == x_rd)));
  assign fwd1  = a_valid && (a_rd != '0) && (a_rd == rs1);
  assign fwd2  = a_valid && (a_rd != '0) && (a_rd == rs2);
endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue into a 1-cycle ALU, hazard tracking through X/A slots, and writeback.
module alu_issue_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [4:0]  alu_opcode,
  output logic [31:0] input_1,
  output logic [31:0] input_2,
  output logic [4:0]  s_r_amount,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] issue_count,
  output logic [31:0] stall_count
);
  instr_t dec;
  logic stall, fwd1, fwd2, accept, issue;
  logic [XLEN-1:0] op1, op2;

  logic [4:0]      opcode_q, opcode_d, shamt_q, shamt_d;
  logic [XLEN-1:0] in1_q, in1_d, in2_q, in2_d;
  logic            x_valid_q, x_valid_d, a_valid_q, a_valid_d;
  logic [REGW-1:0] x_rd_q, x_rd_d, a_rd_q, a_rd_d;
  logic [31:0]     issue_count_q, issue_count_d, stall_count_q, stall_count_d;

  assign dec = decode(instr);

  alu_hazard_unit u_haz (
    .instr_valid (instr_valid),
    .rs1         (dec.rs1),
    .rs2         (dec.rs2),
    .use_imm     (dec.use_imm),
    .x_valid     (x_valid_q),
    .x_rd        (x_rd_q),
    .a_valid     (a_valid_q),
    .a_rd        (a_rd_q),
    .stall       (stall),
    .fwd1        (fwd1),
    .fwd2        (fwd2)
  );

  assign rf_raddr1   = dec.rs1;
  assign rf_raddr2   = dec.rs2;
  assign instr_ready = rst && !stall;
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && (dec.opcode != OP_NOP);

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (dec.rs1 != '0) op1 = fwd1 ? alu_result : rf_rdata1;
    if (dec.rs2 != '0) op2 = fwd2 ? alu_result : rf_rdata2;

    // anything that is not an issued instruction enters X as an all-zero bubble
    opcode_d  = OP_NOP;
    in1_d     = '0;
    in2_d     = '0;
    shamt_d   = '0;
    x_valid_d = 1'b0;
    x_rd_d    = '0;
    if (issue) begin
      opcode_d  = dec.opcode;
      in1_d     = op1;
      in2_d     = dec.use_imm ? {{(XLEN-6){dec.imm6[5]}}, dec.imm6} : op2;
      shamt_d   = dec.shamt;
      x_valid_d = 1'b1;
      x_rd_d    = dec.rd;
    end
    a_valid_d     = x_valid_q;
    a_rd_d        = x_rd_q;
    issue_count_d = issue_count_q + {31'b0, issue};
    stall_count_d = stall_count_q + {31'b0, stall};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode_q      <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      shamt_q       <= '0;
      x_valid_q     <= 1'b0;
      x_rd_q        <= '0;
      a_valid_q     <= 1'b0;
      a_rd_q        <= '0;
      issue_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      opcode_q      <= opcode_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      shamt_q       <= shamt_d;
      x_valid_q     <= x_valid_d;
      x_rd_q        <= x_rd_d;
      a_valid_q     <= a_valid_d;
      a_rd_q        <= a_rd_d;
      issue_count_q <= issue_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign alu_opcode  = opcode_q;
  assign input_1     = in1_q;
  assign input_2     = in2_q;
  assign s_r_amount  = shamt_q;
  assign wb_valid    = rst && a_valid_q && (a_rd_q != '0);
  assign wb_addr     = a_rd_q;
  assign wb_data     = alu_result;
  assign issue_count = issue_count_q;
  assign stall_count = stall_count_q;
endmodule
